// File: rtl/oci_trace_pkg.sv
// Shared constants, code encodings and packer FSM states for the OCI trace path.
package oci_trace_pkg;

    localparam int unsigned DCT_SLOTS = 15;
    localparam int unsigned CODE_W    = 2;
    localparam int unsigned BUF_W     = DCT_SLOTS * CODE_W;
    localparam int unsigned CNT_W     = 4;

    localparam logic [CODE_W-1:0] DCT_TAKEN    = 2'b10;
    localparam logic [CODE_W-1:0] DCT_NOTTAKEN = 2'b11;

    typedef enum logic [1:0] {
        DISABLED,
        COLLECT,
        DRAIN
    } dct_state_e;

    // Only codes with the MSB set carry branch information; 0x codes are idle slots.
    function automatic logic is_branch_code(input logic [CODE_W-1:0] code);
        return code[CODE_W-1];
    endfunction

endpackage

// File: rtl/systemne_nios2_qsys_0_oci_frame_reg.sv
// One-deep valid/ready holding register for completed DCT frames. A frame offered while
// the held frame is still unaccepted is dropped and counted; the held frame is never disturbed.
module systemne_nios2_qsys_0_oci_frame_reg
    import oci_trace_pkg::*;
#(
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [BUF_W-1:0]  load_buf,
    input  logic [CNT_W-1:0]  load_cnt,
    input  logic              frame_ready,
    output logic              frame_valid,
    output logic [BUF_W-1:0]  frame_buf,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    logic slot_free;

    // The slot can take a new frame if empty or being drained this very cycle.
    assign slot_free = !frame_valid || frame_ready;

    // Holding register, handshake and saturating drop accounting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            frame_buf   <= '0;
            frame_cnt   <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (load && slot_free) begin
                frame_valid <= 1'b1;
                frame_buf   <= load_buf;
                frame_cnt   <= load_cnt;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (load && !slot_free) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/systemne_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT branch codes into 15-slot frames and hands them to the trace FIFO.
// Trace never back-pressures the CPU: frames that cannot be accepted are dropped.
module systemne_nios2_qsys_0_oci_dct_packer
    import oci_trace_pkg::*;
#(
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trace_enable,
    input  logic              dct_valid,
    input  logic [CODE_W-1:0] dct_code,
    input  logic              flush,
    input  logic              frame_ready,
    output logic              frame_valid,
    output logic [BUF_W-1:0]  frame_buf,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    dct_state_e       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             emit;
    logic             full;

    assign full = (cnt_q == CNT_W'(DCT_SLOTS));

    // Next state, code acceptance and frame emit decision.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        emit    = 1'b0;
        unique case (state_q)
            DISABLED: begin
                if (trace_enable) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                accept = dct_valid && is_branch_code(dct_code);
                emit   = full || (flush && (cnt_q != '0));
                if (!trace_enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                emit    = (cnt_q != '0);
                state_d = DISABLED;
            end
            default: begin
                state_d = DISABLED;
            end
        endcase
    end

    // Shift buffer: an emit clears it first, so a same-cycle code starts the next frame.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (emit || (state_q == DRAIN)) begin
            buf_d = '0;
            cnt_d = '0;
        end
        if (accept) begin
            buf_d = {buf_d[BUF_W-CODE_W-1:0], dct_code};
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    // FSM state and accumulation buffer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DISABLED;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;

    systemne_nios2_qsys_0_oci_frame_reg #(
        .DROP_W (DROP_W)
    ) u_frame_reg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (emit),
        .load_buf    (buf_q),
        .load_cnt    (cnt_q),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_buf   (frame_buf),
        .frame_cnt   (frame_cnt),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

endmodule

// File: tb/tb_systemne_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the DCT packer: vector table plus hand-written corner sequences,
// with a scoreboard of expected frames popped on each valid/ready handshake.
module tb_systemne_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trace_enable = 1'b0;
    logic        dct_valid = 1'b0;
    logic [1:0]  dct_code = 2'b00;
    logic        flush = 1'b0;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [29:0] frame_buf;
    logic [3:0]  frame_cnt;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic [7:0]  drop_count;

    typedef struct {
        int          n;
        logic [31:0] codes;
        logic [29:0] exp_buf;
        logic [3:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic [29:0] b;
        logic [3:0]  c;
    } frame_t;

    vec_t   vt[6];
    frame_t exp_q[$];
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    systemne_nios2_qsys_0_oci_dct_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trace_enable (trace_enable),
        .dct_valid    (dct_valid),
        .dct_code     (dct_code),
        .flush        (flush),
        .frame_ready  (frame_ready),
        .frame_valid  (frame_valid),
        .frame_buf    (frame_buf),
        .frame_cnt    (frame_cnt),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [29:0] b, input logic [3:0] c);
        frame_t f;
        f.b = b;
        f.c = c;
        exp_q.push_back(f);
    endtask

    // Compare any handshake seen this cycle, then advance to 1 time unit past the next edge.
    task automatic step();
        frame_t f;
        if (frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                f = exp_q.pop_front();
                check("sb_frame_buf", {2'b00, frame_buf}, {2'b00, f.b});
                check("sb_frame_cnt", {28'd0, frame_cnt}, {28'd0, f.c});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input logic [1:0] c);
        dct_valid = 1'b1;
        dct_code  = c;
        step();
        dct_valid = 1'b0;
        dct_code  = 2'b00;
    endtask

    task automatic fill(input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) send_code(c);
    endtask

    initial begin
        vt[0] = '{n: 3,  codes: 32'h0000002E, exp_buf: 30'h0000002E, exp_cnt: 4'd3};
        vt[1] = '{n: 1,  codes: 32'h00000003, exp_buf: 30'h00000003, exp_cnt: 4'd1};
        vt[2] = '{n: 4,  codes: 32'h000000EB, exp_buf: 30'h000000EB, exp_cnt: 4'd4};
        vt[3] = '{n: 15, codes: 32'h3FFFFFFF, exp_buf: 30'h3FFFFFFF, exp_cnt: 4'd15};
        vt[4] = '{n: 5,  codes: 32'h00000272, exp_buf: 30'h0000002E, exp_cnt: 4'd3};
        vt[5] = '{n: 14, codes: 32'h0AAAAAAA, exp_buf: 30'h0AAAAAAA, exp_cnt: 4'd14};

        // Reset state
        step();
        step();
        check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_frame_buf", {2'b00, frame_buf}, 32'd0);
        check("rst_dct_count", {28'd0, dct_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop_count", {24'd0, drop_count}, 32'd0);
        reset_n = 1'b1;
        step();

        // Full frame of taken codes, held until ready
        trace_enable = 1'b1;
        step();
        push(30'h2AAAAAAA, 4'd15);
        fill(2'b10, 15);
        check("t1_count_full", {28'd0, dct_count}, 32'd15);
        step();
        check("t1_frame_valid", {31'd0, frame_valid}, 32'd1);
        check("t1_frame_buf", {2'b00, frame_buf}, 32'h2AAAAAAA);
        check("t1_frame_cnt", {28'd0, frame_cnt}, 32'd15);
        check("t1_dct_count", {28'd0, dct_count}, 32'd0);
        step();
        check("t1_held", {31'd0, frame_valid}, 32'd1);
        frame_ready = 1'b1;
        step();
        step();

        // Table-driven frames terminated by flush
        for (int v = 0; v < 6; v++) begin
            push(vt[v].exp_buf, vt[v].exp_cnt);
            for (int i = 0; i < vt[v].n; i++) send_code(vt[v].codes[2*i +: 2]);
            flush = 1'b1;
            step();
            flush = 1'b0;
            step();
            step();
            check($sformatf("vec%0d_dct_count", v), {28'd0, dct_count}, 32'd0);
            check($sformatf("vec%0d_valid_clr", v), {31'd0, frame_valid}, 32'd0);
        end

        // Flush on an empty buffer produces nothing
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("t2_empty_flush", {31'd0, frame_valid}, 32'd0);

        // 16th code in the emit cycle starts the next frame; back-to-back emit
        push(30'h2AAAAAAA, 4'd15);
        push(30'h00000002, 4'd1);
        fill(2'b10, 16);
        check("t3_frame_cnt", {28'd0, frame_cnt}, 32'd15);
        check("t3_dct_buffer", {2'b00, dct_buffer}, 32'd2);
        check("t3_dct_count", {28'd0, dct_count}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3_b2b_valid", {31'd0, frame_valid}, 32'd1);
        check("t3_b2b_cnt", {28'd0, frame_cnt}, 32'd1);
        step();
        step();

        // Drops while the held frame is not accepted
        frame_ready = 1'b0;
        push(30'h3FFFFFFF, 4'd15);
        fill(2'b11, 15);
        step();
        fill(2'b10, 15);
        step();
        check("t4_held_buf", {2'b00, frame_buf}, 32'h3FFFFFFF);
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        check("t4_drop_1", {24'd0, drop_count}, 32'd1);
        check("t4_cleared", {28'd0, dct_count}, 32'd0);
        for (int i = 0; i < 254; i++) begin
            send_code(2'b10);
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        check("t4_drop_255", {24'd0, drop_count}, 32'd255);
        for (int i = 0; i < 45; i++) begin
            send_code(2'b11);
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        check("t4_drop_sat", {24'd0, drop_count}, 32'd255);
        check("t4_held_cnt", {28'd0, frame_cnt}, 32'd15);
        frame_ready = 1'b1;
        step();
        step();
        check("t4_drained", {31'd0, frame_valid}, 32'd0);

        // Disable mid-frame drains the residual, then codes are ignored
        push(30'h000002EE, 4'd5);
        send_code(2'b10);
        send_code(2'b11);
        send_code(2'b10);
        send_code(2'b11);
        send_code(2'b10);
        trace_enable = 1'b0;
        step();
        step();
        check("t5_valid", {31'd0, frame_valid}, 32'd1);
        check("t5_frame_cnt", {28'd0, frame_cnt}, 32'd5);
        check("t5_dct_count", {28'd0, dct_count}, 32'd0);
        fill(2'b10, 3);
        check("t5_ignored", {28'd0, dct_count}, 32'd0);
        check("t5_ignored_buf", {2'b00, dct_buffer}, 32'd0);
        check("t5_no_frame", {31'd0, frame_valid}, 32'd0);

        // Asynchronous reset mid-frame with a frame pending
        trace_enable = 1'b1;
        frame_ready  = 1'b0;
        step();
        fill(2'b10, 15);
        step();
        fill(2'b11, 3);
        check("t6_pre_valid", {31'd0, frame_valid}, 32'd1);
        check("t6_pre_count", {28'd0, dct_count}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("t6_frame_buf", {2'b00, frame_buf}, 32'd0);
        check("t6_frame_cnt", {28'd0, frame_cnt}, 32'd0);
        check("t6_dct_buffer", {2'b00, dct_buffer}, 32'd0);
        check("t6_dct_count", {28'd0, dct_count}, 32'd0);
        check("t6_overflow", {31'd0, overflow}, 32'd0);
        check("t6_drop_count", {24'd0, drop_count}, 32'd0);
        trace_enable = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        check("sb_all_seen", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
